parity_serial_arbiter: RTL and testbench
========================================

// Module: parity_serial_arbiter
// PURPOSE
//   Shares one 8-bit even/odd parity unit and one serial transmit line between NREQ byte sources.
//   Sources are served round-robin. Each granted byte is sent as an 11-bit frame:
//   start(0), 8 data bits LSB first, parity bit, stop(1).
//   Sits between the byte producers and the serial link pad.
// PARAMETERS
//   NREQ        4   number of requesters; legal values 2..16
//   BIT_CYCLES  4   clocks per serial bit; must be >= 1
//   PARITY_ODD  0   0: even parity (p = ^data); 1: odd parity (p = ~^data)
// PORTS
//   clk         in   1          rising-edge clock
//   rst         in   1          synchronous reset, active-high
//   req_valid   in   NREQ       requester i has a byte pending
//   req_data    in   8*NREQ     byte of requester i in bits [8i+7:8i]
//   req_ready   out  NREQ       one-hot accept strobe, 1 cycle
//   tx_line     out  1          serial output; idles high
//   tx_busy     out  1          high from the cycle after accept until frame end
//   tx_grant_id out  clog2(NREQ) index of the requester currently being sent
//   frame_done  out  1          1-cycle pulse in the last cycle of the stop bit
// BEHAVIOUR
//   Reset values (next edge with rst=1):
//     state=IDLE, tx_line=1, tx_busy=0, tx_grant_id=0, frame_done=0.
//     RR pointer = NREQ-1, so requester 0 has top priority first.
//   States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//   IDLE:
//     - If any req_valid is set, grant the first set bit searching from ptr+1 upward, with wrap.
//     - req_ready[g] is combinational: it is high in that IDLE cycle only.
//     - On the same edge:
//         data_q <= req_data[g]
//         par_q  <= ^req_data[g] ^ PARITY_ODD
//         tx_grant_id <= g
//         ptr <= g
//         state <= START
//     - If no req_valid, stay in IDLE with all req_ready=0.
//   Bit timing:
//     - Each of START/DATA/PARITY/STOP holds tx_line for exactly BIT_CYCLES clocks.
//     - A bit counter runs 0..BIT_CYCLES-1.
//   Per-state line value:
//     - START drives 0.
//     - DATA drives data_q[k] for k=0..7; a 3-bit index advances when the bit counter wraps.
//     - PARITY drives par_q.
//     - STOP drives 1.
//   Latency: tx_line falls on the edge after accept, i.e. one cycle after the req_ready cycle.
//   Frame = 11*BIT_CYCLES clocks.
//   frame_done pulses in the final STOP cycle; the FSM then returns to IDLE.
//   Earliest next accept is the cycle after frame_done.
//   Back-to-back period = 11*BIT_CYCLES + 1 clocks.
//   tx_busy = (state != IDLE). It is registered, aligned with tx_line.
//   Requester contract:
//     - Hold req_valid and req_data stable until req_ready.
//     - Changes to req_data after accept have no effect on the frame in flight.
//     - Deasserting req_valid before grant drops the request without error.
//   Simultaneous events:
//     - Requests arriving during a frame are evaluated only in IDLE.
//     - A requester that was just served has lowest priority next time.
//   Reset mid-frame:
//     - Frame is aborted and tx_line returns to 1 on that edge.
//     - No frame_done pulse is produced.
//     - Pointer returns to NREQ-1.
//   req_ready is forced to 0 while rst=1.
// STRUCTURE
//   Shared package parity_link_pkg:
//     - FSM state typedef/localparams (IDLE, START, DATA, PARITY, STOP).
//     - FRAME_BITS = 11.
//     - function calc_parity(byte, odd).
//   Sub-module rr_arbiter #(NREQ): combinational grant from req_valid and ptr.
//     Outputs one-hot grant, index and any_req. Pointer register lives in the parent.
// TESTING (NREQ=4, BIT_CYCLES=4, PARITY_ODD=0 unless stated)
//   1. Reset, then req0=8'hAA alone.
//      -> req_ready=4'b0001 for 1 cycle.
//      -> tx_line bits 0,0,1,0,1,0,1,0,1,0,1, 4 clocks each.
//      -> frame_done 44 cycles after accept.
//   2. Parity values:
//      -> 8'hAB gives parity bit 1.
//      -> 8'h8C gives parity bit 1.
//      -> 8'h00 gives parity bit 0.
//      -> PARITY_ODD=1 with 8'hAA gives parity bit 1.
//   3. All four req_valid held high.
//      -> grant order 0,1,2,3,0; tx_grant_id matches each frame.
//      -> accepts spaced 45 cycles apart.
//   4. req1 and req3 held high.
//      -> grants alternate 1,3,1,3; req0/req2 ready never asserted.
//   5. rst pulsed at clock 20 of a frame.
//      -> tx_line=1, tx_busy=0 next cycle; no frame_done.
//      -> next grant goes to req0 even if req2 was in flight.
//   6. req2 valid during frame, then dropped before IDLE.
//      -> no grant; line stays idle high.

Source files
------------

// File: rtl/parity_link_pkg.sv
// Shared definitions for the parity serial link: FSM states, frame geometry
// and the parity helper used when a byte is latched.
package parity_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    // odd=0 gives even parity, odd=1 gives odd parity
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first pending requester above ptr, with
// wrap-around. The pointer register itself is owned by the parent.
module rr_arbiter
    import parity_link_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any_req
);

    always_comb begin
        int cand;
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!any_req && req_valid[cand]) begin
                any_req     = 1'b1;
                idx         = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parity_serial_arbiter.sv
// Round-robin sharing of one parity unit and one UART-style transmit line
// between NREQ byte sources; frames are start, 8 data LSB first, parity, stop.
module parity_serial_arbiter
    import parity_link_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int BIT_CYCLES = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx_line,
    output logic                    tx_busy,
    output logic [$clog2(NREQ)-1:0] tx_grant_id,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       data_q, data_n;
    logic             par_q, par_n;
    logic [IDX_W-1:0] ptr;
    logic             bit_last;
    logic             accept;
    logic [7:0]       sel_data;
    logic             line_n;
    logic             done_n;

    logic [NREQ-1:0]  arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .idx       (arb_idx),
        .any_req   (arb_any)
    );

    assign bit_last = (bit_cnt == CNT_LAST);
    assign accept   = (state == ST_IDLE) && arb_any;
    assign sel_data = req_data[8*int'(arb_idx) +: 8];

    always_comb begin
        req_ready = '0;
        if (!rst && state == ST_IDLE) begin
            req_ready = arb_grant;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        bit_idx_n = bit_idx;
        data_n    = data_q;
        par_n     = par_q;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_n   = ST_START;
                    bit_cnt_n = '0;
                    bit_idx_n = '0;
                    data_n    = sel_data;
                    par_n     = calc_parity(sel_data, PARITY_ODD);
                end
            end
            ST_START: begin
                if (bit_last) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = '0;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    bit_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = ST_PARITY;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_last) begin
                    state_n   = ST_STOP;
                    bit_cnt_n = '0;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_last) begin
                    state_n   = ST_IDLE;
                    bit_cnt_n = '0;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                bit_cnt_n = '0;
                bit_idx_n = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        line_n = 1'b1;
        case (state_n)
            ST_START:  line_n = 1'b0;
            ST_DATA:   line_n = data_n[bit_idx_n];
            ST_PARITY: line_n = par_n;
            default:   line_n = 1'b1;
        endcase
        done_n = (state_n == ST_STOP) && (bit_cnt_n == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            ptr         <= IDX_W'(NREQ - 1);
            tx_grant_id <= '0;
            tx_line     <= 1'b1;
            tx_busy     <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            bit_idx    <= bit_idx_n;
            tx_line    <= line_n;
            tx_busy    <= (state_n != ST_IDLE);
            frame_done <= done_n;
            if (accept) begin
                ptr         <= arb_idx;
                tx_grant_id <= arb_idx;
            end
        end
    end

    // Payload registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        data_q <= data_n;
        par_q  <= par_n;
    end

endmodule

// File: tb/tb_parity_serial_arbiter.sv
// Directed bench for parity_serial_arbiter with a frame-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_parity_serial_arbiter;

    localparam int NREQ  = 4;
    localparam int BC    = 4;
    localparam int FRAME = 11 * BC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready;
    logic        tx_line, tx_busy, frame_done;
    logic [1:0]  tx_grant_id;

    logic [3:0]  o_valid = '0;
    logic [31:0] o_data  = '0;
    logic [3:0]  o_ready;
    logic        o_line, o_busy, o_done;
    logic [1:0]  o_gid;

    always #5 clk = ~clk;

    parity_serial_arbiter #(.NREQ(NREQ), .BIT_CYCLES(BC), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_line(tx_line), .tx_busy(tx_busy),
        .tx_grant_id(tx_grant_id), .frame_done(frame_done)
    );

    parity_serial_arbiter #(.NREQ(NREQ), .BIT_CYCLES(BC), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .req_valid(o_valid), .req_data(o_data),
        .req_ready(o_ready), .tx_line(o_line), .tx_busy(o_busy),
        .tx_grant_id(o_gid), .frame_done(o_done)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame position t (0 = idle, 1..FRAME inside a frame)
    bit         m_init = 1'b0;
    int         m_t    = 0;
    int         m_ptr  = NREQ - 1;
    int         m_id   = 0;
    logic [7:0] m_byte = '0;
    int         m_pick;

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic exp_line(input int t, input logic [7:0] b);
        int k;
        if (t == 0) return 1'b1;
        k = (t - 1) / BC;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        m_pick = rr_pick(req_valid, m_ptr);
        if (rst) begin
            m_init <= 1'b1;
            m_t    <= 0;
            m_ptr  <= NREQ - 1;
            m_id   <= 0;
        end else if (m_t == 0) begin
            if (m_pick >= 0) begin
                m_t    <= 1;
                m_ptr  <= m_pick;
                m_id   <= m_pick;
                m_byte <= req_data[8*m_pick +: 8];
            end
        end else if (m_t == FRAME) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    int acc_cyc[$];
    int acc_id[$];
    int acc_vec[$];
    int done_cyc[$];
    int o_acc[$];
    bit line_at[int];
    bit o_line_at[int];
    int rdy02 = 0;

    always @(negedge clk) begin
        logic [3:0] er;
        int pk;
        line_at[cyc]   = tx_line;
        o_line_at[cyc] = o_line;
        if (req_ready != 4'b0) begin
            acc_cyc.push_back(cyc);
            acc_id.push_back(onehot_idx(req_ready));
            acc_vec.push_back(int'(req_ready));
        end
        if (req_ready[0] || req_ready[2]) rdy02++;
        if (frame_done === 1'b1) done_cyc.push_back(cyc);
        if (o_ready != 4'b0) o_acc.push_back(cyc);
        if (m_init) begin
            pk = rr_pick(req_valid, m_ptr);
            er = (rst || m_t != 0 || pk < 0) ? 4'b0 : (4'b1 << pk);
            check("model_req_ready", 32'(req_ready), 32'(er));
            check("model_tx_line", 32'(tx_line), 32'(exp_line(m_t, m_byte)));
            check("model_tx_busy", 32'(tx_busy), 32'(m_t != 0));
            check("model_frame_done", 32'(frame_done), 32'(m_t == FRAME));
            check("model_grant_id", 32'(tx_grant_id), 32'(m_id));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_acc(input int target, input string name);
        int w;
        w = 0;
        while (acc_cyc.size() < target && w < 400) begin
            tick(1);
            w++;
        end
        check(name, 32'(acc_cyc.size() >= target), 32'd1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic send_byte0(input logic [7:0] b, output int a);
        int n;
        n = acc_cyc.size();
        req_data[7:0] = b;
        req_valid     = 4'b0001;
        wait_acc(n + 1, "send_accept_timeout");
        req_valid = 4'b0;
        a = acc_cyc[n];
        tick(FRAME + 2);
    endtask

    initial begin
        int a, n, d, r0, w;
        logic [10:0] pat;
        int exp3[5];
        int exp4[4];

        // Reset with a request already pending: ready must stay low.
        rst           = 1'b1;
        req_data[7:0] = 8'hAA;
        req_valid     = 4'b0001;
        tick(3);
        check("rst_tx_line", 32'(tx_line), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_grant_id", 32'(tx_grant_id), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);

        // 1: single byte 0xAA from requester 0
        rst = 1'b0;
        d   = done_cyc.size();
        n   = acc_cyc.size();
        wait_acc(n + 1, "t1_accept_timeout");
        req_valid = 4'b0;
        a = acc_cyc[n];
        tick(FRAME + 4);
        check("t1_ready_vec", 32'(acc_vec[n]), 32'h1);
        check("t1_ready_one_cycle", 32'(acc_cyc.size()), 32'(n + 1));
        pat = 11'b10101010100;
        check("t1_line_before", 32'(line_at[a]), 32'd1);
        for (int k = 0; k < 11; k++) begin
            for (int j = 0; j < BC; j++) begin
                check($sformatf("t1_bit%0d_c%0d", k, j), 32'(line_at[a + 1 + k*BC + j]), 32'(pat[k]));
            end
        end
        check("t1_line_after", 32'(line_at[a + FRAME + 1]), 32'd1);
        check("t1_done_count", 32'(done_cyc.size()), 32'(d + 1));
        if (done_cyc.size() > d) check("t1_done_latency", 32'(done_cyc[d] - a), 32'd44);

        // 2: parity bit for several bytes, then odd parity instance
        send_byte0(8'hAB, a);
        check("t2_par_AB", 32'(line_at[a + 1 + 9*BC + 1]), 32'd1);
        send_byte0(8'h8C, a);
        check("t2_par_8C", 32'(line_at[a + 1 + 9*BC + 1]), 32'd1);
        send_byte0(8'h00, a);
        check("t2_par_00", 32'(line_at[a + 1 + 9*BC + 1]), 32'd0);
        n = o_acc.size();
        o_data[7:0] = 8'hAA;
        o_valid     = 4'b0001;
        w = 0;
        while (o_acc.size() <= n && w < 100) begin
            tick(1);
            w++;
        end
        o_valid = 4'b0;
        check("t2_odd_accept", 32'(o_acc.size() > n), 32'd1);
        if (o_acc.size() > n) begin
            a = o_acc[n];
            tick(FRAME + 2);
            check("t2_odd_par_AA", 32'(o_line_at[a + 1 + 9*BC + 1]), 32'd1);
            check("t2_odd_d1", 32'(o_line_at[a + 1 + 2*BC + 1]), 32'd1);
        end

        // 3: all four requesting
        pulse_rst();
        req_data  = 32'h44332211;
        n         = acc_cyc.size();
        req_valid = 4'hF;
        wait_acc(n + 5, "t3_accept_timeout");
        req_valid = 4'b0;
        tick(FRAME + 2);
        exp3 = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_grant%0d", i), 32'(acc_id[n + i]), 32'(exp3[i]));
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_gap%0d", i), 32'(acc_cyc[n + i + 1] - acc_cyc[n + i]), 32'd45);
        end

        // 4: requesters 1 and 3 alternate
        pulse_rst();
        r0        = rdy02;
        n         = acc_cyc.size();
        req_valid = 4'b1010;
        wait_acc(n + 4, "t4_accept_timeout");
        req_valid = 4'b0;
        tick(FRAME + 2);
        exp4 = '{1, 3, 1, 3};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_grant%0d", i), 32'(acc_id[n + i]), 32'(exp4[i]));
        end
        check("t4_no_ready_0_2", 32'(rdy02 - r0), 32'd0);

        // 5: reset at frame clock 20
        pulse_rst();
        n         = acc_cyc.size();
        req_valid = 4'b0100;
        wait_acc(n + 1, "t5_accept_timeout");
        req_valid = 4'b0;
        a = acc_cyc[n];
        check("t5_first_grant", 32'(acc_id[n]), 32'd2);
        while (cyc < a + 20) tick(1);
        d = done_cyc.size();
        pulse_rst();
        check("t5_line_after_rst", 32'(tx_line), 32'd1);
        check("t5_busy_after_rst", 32'(tx_busy), 32'd0);
        tick(FRAME + 4);
        check("t5_no_done", 32'(done_cyc.size()), 32'(d));
        n         = acc_cyc.size();
        req_valid = 4'b0101;
        wait_acc(n + 1, "t5_regrant_timeout");
        req_valid = 4'b0;
        check("t5_regrant_id", 32'(acc_id[n]), 32'd0);
        tick(FRAME + 2);

        // 6: request raised and dropped during a frame is never granted
        n             = acc_cyc.size();
        req_data[15:8] = 8'h5A;
        req_valid     = 4'b0010;
        wait_acc(n + 1, "t6_accept_timeout");
        req_valid = 4'b0;
        a = acc_cyc[n];
        tick(10);
        req_valid = 4'b0100;
        tick(20);
        req_valid = 4'b0;
        tick(FRAME);
        check("t6_no_extra_grant", 32'(acc_cyc.size()), 32'(n + 1));
        d = 1;
        for (int c = a + FRAME + 1; c < a + FRAME + 16; c++) if (!line_at[c]) d = 0;
        check("t6_line_idle_high", 32'(d), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
